// File: rtl/ysyx_24080014_alu_mc_if.sv
// Decode-to-execute-to-writeback handshake bundle for the multi-cycle execute unit.
// Upstream side is valid/ready on operands; downstream side is valid/ready on results.
interface ysyx_24080014_alu_mc_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            br_taken;
    logic            err;

    modport master (
        output in_valid, op, a, b, pc, imm, out_ready,
        input  in_ready, out_valid, result, br_taken, err
    );

    modport slave (
        input  in_valid, op, a, b, pc, imm, out_ready,
        output in_ready, out_valid, result, br_taken, err
    );
endinterface

// File: rtl/ysyx_24080014_alu_mc.sv
// Execute unit: ALU, branch/next-PC, iterative MUL/DIV when YSYX_24080014_ALU_MULDIV_EN is defined.
// Latency 1 (ALU/branch/illegal/div special case), XLEN+1 for mul/div; in_ready low while busy or result stalled.
module ysyx_24080014_alu_mc #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_24080014_alu_mc_if.slave   bus
);
    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_PASSB = 5'd10;
    localparam logic [4:0] OP_BEQ   = 5'd11;
    localparam logic [4:0] OP_BNE   = 5'd12;
    localparam logic [4:0] OP_BLT   = 5'd13;
    localparam logic [4:0] OP_BGE   = 5'd14;
    localparam logic [4:0] OP_BLTU  = 5'd15;
    localparam logic [4:0] OP_BGEU  = 5'd16;

`ifdef YSYX_24080014_ALU_MULDIV_EN
    localparam logic [4:0] OP_MUL    = 5'd17;
    localparam logic [4:0] OP_MULH   = 5'd18;
    localparam logic [4:0] OP_MULHSU = 5'd19;
    localparam logic [4:0] OP_MULHU  = 5'd20;
    localparam logic [4:0] OP_DIV    = 5'd21;
    localparam logic [4:0] OP_DIVU   = 5'd22;
    localparam logic [4:0] OP_REM    = 5'd23;
    localparam logic [4:0] OP_REMU   = 5'd24;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DONE, S_MUL, S_DIV} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

    state_t          r_state;
    state_t          w_next;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_br;
    logic            r_err;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_consume;
    logic            w_go_multi;
    logic            w_lt;
    logic            w_ltu;
    logic            w_br;
    logic            w_err;
    logic [XLEN-1:0] w_res;

    assign w_in_ready    = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept      = bus.in_valid && w_in_ready;
    assign w_consume     = r_out_valid && bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.br_taken  = r_br;
    assign bus.err       = r_err;

`ifdef YSYX_24080014_ALU_MULDIV_EN
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_mcand;
    logic [SHW-1:0]    r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_sel_hi;

    logic              w_is_mul, w_is_div, w_div_special, w_b_zero;
    logic              w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next, w_mul_prod, w_div_next;
    logic [XLEN:0]     w_div_sh;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_sub, w_q, w_r, w_mul_res, w_div_res;

    assign w_is_mul = (bus.op >= OP_MUL) && (bus.op <= OP_MULHU);
    assign w_is_div = (bus.op >= OP_DIV) && (bus.op <= OP_REMU);
    assign w_b_zero = (bus.b == '0);
    assign w_a_neg  = bus.a[XLEN-1] && (bus.op == OP_MUL || bus.op == OP_MULH ||
                      bus.op == OP_MULHSU || bus.op == OP_DIV || bus.op == OP_REM);
    assign w_b_neg  = bus.b[XLEN-1] && (bus.op == OP_MUL || bus.op == OP_MULH ||
                      bus.op == OP_DIV || bus.op == OP_REM);
    assign w_a_mag  = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag  = w_b_neg ? -bus.b : bus.b;
    assign w_div_special = w_is_div && (w_b_zero ||
                           ((bus.op == OP_DIV || bus.op == OP_REM) &&
                            bus.a == MOST_NEG && bus.b == '1));
    assign w_go_multi = w_is_mul || (w_is_div && !w_div_special);

    // Shift-add: low half holds the remaining multiplier bits, high half the partial sum.
    assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_next = {w_mul_sum, r_prod[XLEN-1:1]};
    assign w_mul_prod = r_neg_q ? -w_mul_next : w_mul_next;
    assign w_mul_res  = r_sel_hi ? w_mul_prod[2*XLEN-1:XLEN] : w_mul_prod[XLEN-1:0];

    // Restoring divide: high half is the partial remainder, low half shifts dividend out, quotient in.
    assign w_div_sh   = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
    assign w_div_ge   = w_div_sh >= {1'b0, r_mcand};
    assign w_div_sub  = w_div_sh[XLEN-1:0] - r_mcand;
    assign w_div_next = w_div_ge ? {w_div_sub, r_prod[XLEN-2:0], 1'b1}
                                 : {w_div_sh[XLEN-1:0], r_prod[XLEN-2:0], 1'b0};
    assign w_q        = w_div_next[XLEN-1:0];
    assign w_r        = w_div_next[2*XLEN-1:XLEN];
    assign w_div_res  = r_sel_hi ? (r_neg_r ? -w_r : w_r) : (r_neg_q ? -w_q : w_q);
`else
    assign w_go_multi = 1'b0;
`endif

    always_comb begin
        w_res = '0;
        w_br  = 1'b0;
        w_err = 1'b0;
        w_lt  = $signed(bus.a) < $signed(bus.b);
        w_ltu = bus.a < bus.b;
        case (bus.op)
            OP_ADD:   w_res = bus.a + bus.b;
            OP_SUB:   w_res = bus.a - bus.b;
            OP_AND:   w_res = bus.a & bus.b;
            OP_OR:    w_res = bus.a | bus.b;
            OP_XOR:   w_res = bus.a ^ bus.b;
            OP_SLL:   w_res = bus.a << bus.b[SHW-1:0];
            OP_SRL:   w_res = bus.a >> bus.b[SHW-1:0];
            OP_SRA:   w_res = $unsigned($signed(bus.a) >>> bus.b[SHW-1:0]);
            OP_SLT:   w_res = XLEN'(w_lt);
            OP_SLTU:  w_res = XLEN'(w_ltu);
            OP_PASSB: w_res = bus.b;
            OP_BEQ:   w_br  = (bus.a == bus.b);
            OP_BNE:   w_br  = (bus.a != bus.b);
            OP_BLT:   w_br  = w_lt;
            OP_BGE:   w_br  = !w_lt;
            OP_BLTU:  w_br  = w_ltu;
            OP_BGEU:  w_br  = !w_ltu;
`ifdef YSYX_24080014_ALU_MULDIV_EN
            // Only reached for the divide special cases; regular mul/div go multi-cycle.
            OP_DIV, OP_DIVU: w_res = w_b_zero ? '1 : bus.a;
            OP_REM, OP_REMU: w_res = w_b_zero ? bus.a : '0;
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: w_res = '0;
`endif
            default:  w_err = 1'b1;
        endcase
        if (bus.op >= OP_BEQ && bus.op <= OP_BGEU)
            w_res = w_br ? (bus.pc + bus.imm) : (bus.pc + XLEN'(4));
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_out_valid && !bus.out_ready) w_next = S_DONE;
`ifdef YSYX_24080014_ALU_MULDIV_EN
                if (w_accept && w_go_multi) w_next = w_is_mul ? S_MUL : S_DIV;
`endif
            end
            S_DONE: if (bus.out_ready) w_next = S_IDLE;
`ifdef YSYX_24080014_ALU_MULDIV_EN
            S_MUL, S_DIV: if (r_cnt == '0) w_next = S_DONE;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_br        <= 1'b0;
            r_err       <= 1'b0;
`ifdef YSYX_24080014_ALU_MULDIV_EN
            r_prod      <= '0;
            r_mcand     <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_sel_hi    <= 1'b0;
`endif
        end else begin
            if (w_consume) begin
                r_out_valid <= 1'b0;
                r_br        <= 1'b0;
                r_err       <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept && !w_go_multi) begin
                        r_result    <= w_res;
                        r_br        <= w_br;
                        r_err       <= w_err;
                        r_out_valid <= 1'b1;
                    end
`ifdef YSYX_24080014_ALU_MULDIV_EN
                    if (w_accept && w_go_multi) begin
                        r_prod   <= {{XLEN{1'b0}}, w_a_mag};
                        r_mcand  <= w_b_mag;
                        r_cnt    <= SHW'(XLEN-1);
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_sel_hi <= (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                                    (bus.op == OP_MULHU) || (bus.op == OP_REM) ||
                                    (bus.op == OP_REMU);
                    end
`endif
                end
`ifdef YSYX_24080014_ALU_MULDIV_EN
                // Last iteration and sign fix-up share a cycle so the result lands XLEN+1 after accept.
                S_MUL, S_DIV: begin
                    if (r_cnt == '0) begin
                        r_result    <= (r_state == S_MUL) ? w_mul_res : w_div_res;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_prod <= (r_state == S_MUL) ? w_mul_next : w_div_next;
                        r_cnt  <= r_cnt - 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: doc/ysyx_24080014_alu_mc.md
Name: ysyx_24080014_alu_mc

Overview:
Parametrised multi-cycle execute unit for the NPC core. It is the successor to the single-cycle ALU.
- Covers integer ALU ops, branch resolution and next-PC computation.
- Adds iterative RV M-extension multiply/divide.
- Sits between decode and writeback, with valid/ready handshakes on both sides.
- A single-cycle op takes 1 cycle. Multiply and divide occupy the unit for XLEN+1 cycles.

Parameters:
- XLEN, 32, datapath width; must be a power of two, 32 or 64.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts operation.
- op  in  5  operation code (see Behaviour).
- a  in  XLEN  operand 1 (rs1).
- b  in  XLEN  operand 2 (rs2 or immediate).
- pc  in  XLEN  PC of instruction.
- imm  in  XLEN  branch offset.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  ALU result, or next PC for branches.
- br_taken  out  1  branch condition true (branch ops only, else 0).
- err  out  1  unsupported op code.

Behaviour:
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is b[SHW-1:0].
  - 8 SLT (signed), 9 SLTU; result is 1 or 0.
  - 10 PASSB (result = b; used for LUI).
  - 11 BEQ, 12 BNE, 13 BLT, 14 BGE, 15 BLTU, 16 BGEU.
  - 17 MUL, 18 MULH, 19 MULHSU, 20 MULHU, 21 DIV, 22 DIVU, 23 REM, 24 REMU.
  - 25-31 illegal.
- Branch ops: result = br_taken ? pc+imm : pc+4. All adds wrap modulo 2^XLEN.
- Accept: a transfer occurs when in_valid && in_ready. Operands are latched on the accept cycle.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- State machine:
  - IDLE: on accept of a single-cycle op, an illegal op, or a divide special case, compute and register the result. Go to DONE the next cycle. Latency 1.
  - IDLE: on accept of MUL* go to MUL; on accept of DIV/REM (non-special) go to DIV.
  - MUL: radix-2 shift-add over 2*XLEN-bit product of the magnitudes. Counter runs XLEN-1..0. Apply sign correction at the end. Then go to DONE. out_valid asserts XLEN+1 cycles after accept.
  - DIV: restoring division of the magnitudes over XLEN iterations. Apply signs: quotient sign = sign(a)^sign(b); remainder takes the sign of a. Then go to DONE. Same latency as MUL.
  - DONE: out_valid=1, outputs stable. If out_ready, go to IDLE.
- Back-to-back: a single-cycle op may be accepted in the same cycle the previous result is consumed (IDLE with out_valid && out_ready). Throughput is 1 op/cycle for single-cycle ops.
- Divide special cases (latency 1):
  - b==0: quotient all ones, remainder = a.
  - Signed DIV/REM with a = most-negative and b = -1: quotient = a, remainder = 0.
- MULH/MULHSU/MULHU return the upper XLEN bits; MUL returns the lower XLEN bits.
- Illegal op: result=0, br_taken=0, err=1, latency 1.
- err and br_taken are valid only while out_valid; otherwise they are 0.
- in_valid while busy: ignored (in_ready=0); upstream holds.
- Reset values: state=IDLE, out_valid=0, result=0, br_taken=0, err=0, in_ready=1 after reset deasserts, counter=0.
- Reset mid-MUL/DIV: the operation is abandoned and no result is produced.

Optional Feature:
- Macro YSYX_24080014_ALU_MULDIV_EN.
- Defined: MUL/DIV datapath, MUL and DIV states, and the iteration counter are built.
- Undefined: ops 17-24 are treated as illegal (result 0, err=1, latency 1). The MUL/DIV logic is not synthesised.

Test Plan:
- ADD a=0xFFFFFFFF, b=1 -> result 0x00000000, 1-cycle latency. SRA a=0x80000000, b=0x21 -> 0xC0000000 (shift amount 1).
- BLT a=-5, b=3, pc=0x80000000, imm=0x10 -> br_taken=1, result 0x80000010. BGEU with the same operands -> br_taken=1, result 0x80000010.
- MULH a=0x80000000, b=0x80000000 -> result 0x40000000, out_valid exactly 33 cycles after accept. MULHSU a=-1, b=2 -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> -3 (0xFFFFFFFD); REM -> -1. DIVU a=7, b=0 -> 0xFFFFFFFF, latency 1. DIV a=0x80000000, b=-1 -> 0x80000000.
- Hold out_ready=0 for 5 cycles after DONE -> result and out_valid stable, in_ready=0. Assert rst during DIV iteration 10 -> out_valid stays 0, in_ready=1 the following cycle.
- Op 27 -> err=1, result 0. With the macro undefined, MUL 3*4 -> err=1, result 0.
